thermo_frame_loader: RTL
========================

# thermo_frame_loader

Upstream feeder for the `onenot` nine-lane comparator. It accepts a serial stream of 5-bit level counts over a valid/ready handshake and converts each count to a 16-bit thermometer code (ones packed from the LSB). It assembles nine codes into a frame on the registered lanes `A`..`I`, then holds the frame under an `out_valid`/`out_ready` handshake until the downstream stage consumes it.

## Interface
- `WIDTH`, 16: lane width in bits. It is also the maximum legal count.
- `CNT_W`, 5: count input width. Must satisfy 2^CNT_W > WIDTH.
- `clk` in 1: sole clock. All state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous abort of a partial frame.
- `in_valid` in 1: `in_count` is valid.
- `in_ready` out 1: loader can accept a count this cycle.
- `in_count` in CNT_W: number of ones for the next lane.
- `A`,`B`,`C`,`D`,`E`,`F`,`G`,`H`,`I` out WIDTH each: registered lane codes, filled in that order.
- `out_valid` out 1: all nine lanes hold a complete frame.
- `out_ready` in 1: downstream accepts the frame.
- `ovf` out 1: at least one count in the current frame exceeded `WIDTH`.

## Operation
- Conversion: `code = (1 << in_count) - 1` for `in_count <= WIDTH`.
  - `in_count = 0` gives all zeros.
  - `in_count > WIDTH` saturates to all ones and sets `ovf`.
- There are two states, FILL and HOLD. A 4-bit lane index `idx` runs 0..8 and maps 0→A through 8→I.
- FILL:
  - `in_ready = !flush`.
  - On accept (`in_valid && in_ready`), write the code into lane `idx` and increment `idx`.
  - Accepting with `idx == 8` writes lane I, sets `idx = 0`, sets `out_valid = 1` and moves to HOLD.
- HOLD:
  - `in_ready = out_ready`.
  - `A`..`I` and `ovf` stay frozen while `out_ready = 0`.
  - On `out_ready = 1`, clear `out_valid` and move to FILL.
  - If a count is accepted in that same cycle, it is written to lane A, `idx` becomes 1, and `ovf` is reloaded from that count alone.
- `ovf` is sticky within a frame. It clears when a frame is consumed and when a partial frame is flushed.
- `flush`:
  - In FILL, it sets `idx = 0`, clears `ovf`, and zeroes all lanes. The same-cycle input is not accepted, because `in_ready = 0`.
  - In HOLD, `flush` is ignored. A complete frame is never discarded.
- Lanes not yet written in the current frame keep their previous-frame values. Their contents are only guaranteed while `out_valid = 1`.
- `idx` never exceeds 8 and no lane beyond I exists.
- Reset values:
  - State FILL, `idx = 0`.
  - `A`..`I` = 0.
  - `out_valid = 0`, `ovf = 0`.
  - `in_ready = 1` once `rst` deasserts, if `flush = 0`.

## Timing
- Lane registers update on the edge at which the count is accepted. The code is visible on the lane output the following cycle.
- Frame latency is one cycle: `out_valid` rises the cycle after the 9th accept.
- Maximum throughput is one count per clock. Back-to-back frames need no bubble when `out_ready` is held high, so 9 counts are consumed in 9 consecutive cycles per frame.
- With `out_ready = 0`, `in_ready` stays low for the whole of HOLD, so inputs stall indefinitely and no count is lost.
- Reset mid-frame clears all state immediately, asynchronously. Partial frames are discarded and no `out_valid` pulse is produced.
- All outputs are driven directly from flops except `in_ready`, which is combinational from state, `flush` and `out_ready`.

## Test plan
- Basic frame:
  - Stimulus: reset, then counts 5,8,4,10,14,9,6,13,2 on consecutive cycles with `out_ready = 0`.
  - Response: `out_valid` rises one cycle after the 9th accept, with A=0x001F, B=0x00FF, C=0x000F, D=0x03FF, E=0x3FFF, F=0x01FF, G=0x003F, H=0x1FFF, I=0x0003 and `ovf = 0`. All values hold for 20 cycles of stall, with `in_ready = 0` throughout.
- Boundaries and saturation:
  - Stimulus: counts 0,16,17,31,1,15,0,16,3.
  - Response: A=0x0000, B=0xFFFF, C=0xFFFF, D=0xFFFF, E=0x0001, F=0x7FFF, G=0x0000, H=0xFFFF, I=0x0007, `ovf = 1`.
  - Follow-up: a clean next frame shows `ovf = 0`.
- Back-to-back frames:
  - Stimulus: `out_ready = 1` and `in_valid = 1` continuously for 18 counts.
  - Response: two `out_valid` pulses, each one cycle wide and 9 cycles apart, with no count dropped or duplicated.
  - Check: the first count of frame 2 is accepted in the same cycle frame 1 is consumed and lands in A.
- Flush:
  - Stimulus: 4 counts, then `flush` together with `in_valid`, then 9 counts 1..9.
  - Response: the flushed-cycle count is not accepted, the lanes read 0 after the flush, and the final frame is A=0x0001 … I=0x01FF.
  - Check: a `flush` asserted during HOLD leaves the frame and `out_valid` unchanged.
- Async reset mid-frame:
  - Stimulus: assert `rst` between clock edges after 6 accepts.
  - Response: lanes read 0, `out_valid = 0` and `ovf = 0` immediately.
  - Follow-up: 9 fresh counts after release produce a correct frame.
- Input gaps:
  - Stimulus: `in_valid` toggled randomly across the 9 counts.
  - Response: lanes fill strictly in A..I order, and `out_valid` asserts only after the 9th accepted count.

Source files
------------

// File: rtl/thermo_frame_loader.sv
// Serial level-count to thermometer-code frame builder: nine 5-bit counts become
// nine 16-bit thermometer lanes A..I, presented under an out_valid/out_ready handshake.
module thermo_frame_loader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_count,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic [WIDTH-1:0] I,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int unsigned      NUM_LANES = 9;
  localparam int unsigned      IDX_W     = 4;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(WIDTH);

  typedef enum logic {
    S_FILL,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] lane_q [NUM_LANES];
  logic [WIDTH-1:0] lane_d [NUM_LANES];
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             sat;
  logic [WIDTH:0]   pow2;
  logic [WIDTH-1:0] code;

  // Count to thermometer code; one extra bit lets count == WIDTH wrap to all ones.
  always_comb begin
    sat  = in_count > MAX_CNT;
    pow2 = (WIDTH+1)'(1) << in_count;
    code = sat ? '1 : WIDTH'(pow2 - (WIDTH+1)'(1));
  end

  // Next-state, lane write and handshake logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    lane_d      = lane_q;
    in_ready    = 1'b0;

    case (state_q)
      S_FILL: begin
        in_ready = !flush;
        if (flush) begin
          idx_d = '0;
          ovf_d = 1'b0;
          for (int unsigned k = 0; k < NUM_LANES; k++) begin
            lane_d[k] = '0;
          end
        end else if (in_valid) begin
          for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (idx_q == IDX_W'(k)) begin
              lane_d[k] = code;
            end
          end
          ovf_d = ovf_q | sat;
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_HOLD: begin
        // Frame is frozen until consumed; a same-cycle count opens the next frame.
        in_ready = out_ready;
        if (out_ready) begin
          state_d     = S_FILL;
          out_valid_d = 1'b0;
          ovf_d       = 1'b0;
          if (in_valid) begin
            lane_d[0] = code;
            idx_d     = IDX_W'(1);
            ovf_d     = sat;
          end
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        lane_q[k] <= lane_d[k];
      end
    end
  end

  assign A         = lane_q[0];
  assign B         = lane_q[1];
  assign C         = lane_q[2];
  assign D         = lane_q[3];
  assign E         = lane_q[4];
  assign F         = lane_q[5];
  assign G         = lane_q[6];
  assign H         = lane_q[7];
  assign I         = lane_q[8];
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule
